// File: rtl/pmu_reader.sv
// Performance-monitor reader: atomically snapshots NUM_CNT counters on request or timer
// and streams them as a framed word sequence (header, then low/high halves) over valid/ready.
module pmu_reader #(
    parameter int NUM_CNT = 6,
    parameter int CNT_W   = 64,
    parameter int OUT_W   = 32,
    parameter int PERIOD  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
    input  logic                     req,
    input  logic                     delta_mode,
    output logic                     busy,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [7:0]               seq,
    output logic [15:0]              drop_cnt
);
    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NUM_CNT);
    localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;

    state_t             state_r, state_next_s;
    logic [CNT_W-1:0]   snap_r [NUM_CNT];
    logic [CNT_W-1:0]   prev_r [NUM_CNT];
    logic [IDX_W-1:0]   idx_r, next_idx_s, cnt_sel_s;
    logic               mode_r;
    logic               busy_r, out_valid_r, out_last_r;
    logic [OUT_W-1:0]   out_data_r, word_s, header_s;
    logic [7:0]         seq_r;
    logic [15:0]        drop_cnt_r;
    logic               timer_hit_s, trig_s;
    logic               capture_s, advance_s, finish_s, drop_s;

    generate
        if (PERIOD > 0) begin : g_timer
            logic [TMR_W-1:0] timer_r;
            // Free-running sample timer, wraps after PERIOD-1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    timer_r <= {TMR_W{1'b0}};
                end else if (timer_r == TMR_W'(PERIOD - 1)) begin
                    timer_r <= {TMR_W{1'b0}};
                end else begin
                    timer_r <= timer_r + TMR_W'(1);
                end
            end
            assign timer_hit_s = (timer_r == TMR_W'(PERIOD - 1));
        end else begin : g_no_timer
            assign timer_hit_s = 1'b0;
        end
    endgenerate

    assign trig_s   = req | timer_hit_s;
    assign header_s = {8'hA5, seq_r, 4'(NUM_CNT), 11'b0, delta_mode};

    // Selects the stream word that follows the current index
    always_comb begin
        next_idx_s = idx_r + IDX_W'(1);
        cnt_sel_s  = (next_idx_s - IDX_W'(1)) >> 1;
        word_s     = {OUT_W{1'b0}};
        for (int i = 0; i < NUM_CNT; i++) begin
            if (cnt_sel_s == IDX_W'(i)) begin
                if (next_idx_s[0]) begin
                    word_s = snap_r[i][OUT_W-1:0];
                end else begin
                    word_s = snap_r[i][CNT_W-1:OUT_W];
                end
            end else begin
                word_s = word_s;
            end
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        advance_s    = 1'b0;
        finish_s     = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trig_s) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                drop_s = trig_s;
                if (out_valid_r && out_ready) begin
                    if (idx_r == LAST_IDX) begin
                        finish_s     = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        advance_s    = 1'b1;
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Atomic snapshot and delta base capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap_r[i] <= {CNT_W{1'b0}};
                prev_r[i] <= {CNT_W{1'b0}};
            end
        end else if (capture_s) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap_r[i] <= delta_mode ? (cnt_in[i*CNT_W +: CNT_W] - prev_r[i])
                                        : cnt_in[i*CNT_W +: CNT_W];
                prev_r[i] <= cnt_in[i*CNT_W +: CNT_W];
            end
        end
    end

    // FSM state, stream output registers, sequence and drop counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            mode_r      <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            seq_r       <= 8'd0;
            drop_cnt_r  <= 16'd0;
        end else begin
            state_r <= state_next_s;
            if (capture_s) begin
                idx_r       <= {IDX_W{1'b0}};
                mode_r      <= delta_mode;
                busy_r      <= 1'b1;
                out_valid_r <= 1'b1;
                out_last_r  <= 1'b0;
                out_data_r  <= header_s;
            end else if (advance_s) begin
                idx_r      <= next_idx_s;
                out_data_r <= word_s;
                out_last_r <= (next_idx_s == LAST_IDX);
            end else if (finish_s) begin
                busy_r      <= 1'b0;
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
                out_data_r  <= {OUT_W{1'b0}};
                seq_r       <= seq_r + 8'd1;
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    assign busy      = busy_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign seq       = seq_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_pmu_reader.sv
// Bench for pmu_reader: directed vectors, corner sequences and a randomized run
// checked against a frame-level reference model; second instance exercises the timer.
module tb_pmu_reader;
    localparam int N = 6;

    logic              clk = 1'b0;
    logic              rst_n, rst_n_p;
    logic [N*64-1:0]   cnt_in, cnt_in_p;
    logic              req, delta_mode, out_ready;
    logic              busy, out_valid, out_last;
    logic [31:0]       out_data;
    logic [7:0]        seq;
    logic [15:0]       drop_cnt;
    logic              busy_p, out_valid_p, out_last_p;
    logic [31:0]       out_data_p;
    logic [7:0]        seq_p;
    logic [15:0]       drop_cnt_p;

    int checks = 0;
    int failures = 0;

    // Reference model state: remaining words of the frame in flight ({last, data})
    logic [32:0] m_q[$];
    logic [63:0] m_prev[N];
    logic [63:0] cnt_v[N];
    int          m_seq, m_drop;

    always #5 clk = ~clk;

    pmu_reader #(.NUM_CNT(N)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .req(req), .delta_mode(delta_mode),
        .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .seq(seq), .drop_cnt(drop_cnt));

    pmu_reader #(.NUM_CNT(N), .PERIOD(50)) dut_p (
        .clk(clk), .rst_n(rst_n_p), .cnt_in(cnt_in_p), .req(1'b0), .delta_mode(1'b0),
        .busy(busy_p), .out_data(out_data_p), .out_valid(out_valid_p), .out_ready(1'b1),
        .out_last(out_last_p), .seq(seq_p), .drop_cnt(drop_cnt_p));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply_cnt();
        for (int i = 0; i < N; i++) cnt_in[i*64 +: 64] = cnt_v[i];
    endtask

    task automatic model_reset();
        m_q.delete();
        m_seq = 0;
        m_drop = 0;
        for (int i = 0; i < N; i++) m_prev[i] = 64'd0;
    endtask

    // Applies the cycle's inputs to the frame-level model
    task automatic model_update();
        logic [63:0] v;
        if (m_q.size() > 0) begin
            if (req && m_drop < 65535) m_drop++;
            if (out_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_seq = (m_seq + 1) % 256;
            end
        end else if (req) begin
            m_q.push_back({1'b0, 8'hA5, 8'(m_seq), 4'(N), 11'd0, delta_mode});
            for (int i = 0; i < N; i++) begin
                v = delta_mode ? (cnt_in[i*64 +: 64] - m_prev[i]) : cnt_in[i*64 +: 64];
                m_prev[i] = cnt_in[i*64 +: 64];
                m_q.push_back({1'b0, v[31:0]});
                m_q.push_back({(i == N - 1), v[63:32]});
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid", 64'(out_valid), 64'(m_q.size() > 0));
        chk("busy", 64'(busy), 64'(m_q.size() > 0));
        chk("seq", 64'(seq), 64'(m_seq));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (m_q.size() > 0) begin
            chk("data", 64'(out_data), 64'(m_q[0][31:0]));
            chk("last", 64'(out_last), 64'(m_q[0][32]));
        end else begin
            chk("last_idle", 64'(out_last), 64'd0);
        end
    endtask

    // One clock cycle: drive at negedge, advance model, check at next negedge
    task automatic step(input logic r, input logic rdy, input logic dm);
        req = r;
        out_ready = rdy;
        delta_mode = dm;
        apply_cnt();
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        int n = 0;
        while (m_q.size() > 0 && n < 40) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_bound", 64'(m_q.size()), 64'd0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic        r;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
        logic [7:0]  exp_seq;
    } vec_t;

    initial begin
        vec_t        tbl[14];
        logic [31:0] words[12];
        int          n, hdr_n, ecount;
        logic        pv;
        logic [7:0]  seq0;
        int          drop0;

        rst_n = 1'b0; rst_n_p = 1'b0;
        req = 1'b0; out_ready = 1'b0; delta_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt_v[i] = 64'd0;
            cnt_in_p[i*64 +: 64] = 64'h1111_0000_0000_0000 + 64'(i);
        end
        apply_cnt();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_seq", 64'(seq), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);

        // Absolute readout vectors
        for (int i = 0; i < 5; i++) cnt_v[i] = 64'(i + 1);
        cnt_v[5] = 64'h0000_0001_FFFF_FFFF;
        words = '{32'h1, 32'h0, 32'h2, 32'h0, 32'h3, 32'h0, 32'h4, 32'h0,
                  32'h5, 32'h0, 32'hFFFF_FFFF, 32'h1};
        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'hA500_6000, 1'b0, 8'd0};
        for (int j = 1; j <= 12; j++) tbl[j] = '{1'b0, 1'b1, 1'b1, words[j-1], (j == 12), 8'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 8'd1};
        for (int j = 0; j < 14; j++) begin
            step(tbl[j].r, tbl[j].rdy, 1'b0);
            cnt_v[0] = cnt_v[0] + 64'd7;
            chk($sformatf("vec%0d_valid", j), 64'(out_valid), 64'(tbl[j].exp_valid));
            if (tbl[j].exp_valid) begin
                chk($sformatf("vec%0d_data", j), 64'(out_data), 64'(tbl[j].exp_data));
            end
            chk($sformatf("vec%0d_last", j), 64'(out_last), 64'(tbl[j].exp_last));
            chk($sformatf("vec%0d_seq", j), 64'(seq), 64'(tbl[j].exp_seq));
        end

        // Backpressure: ready toggles starting low on the header cycle
        step(1'b1, 1'b1, 1'b0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, logic'(k % 2), 1'b0);
            n++;
            if (!out_valid) break;
        end
        chk("bp_cycles", 64'(n), 64'd26);
        step(1'b0, 1'b1, 1'b0);

        // Delta wrap across 2^64
        cnt_v[0] = 64'hFFFF_FFFF_FFFF_FFF0;
        step(1'b1, 1'b1, 1'b0);
        drain();
        cnt_v[0] = 64'h10;
        seq0 = seq;
        step(1'b1, 1'b1, 1'b1);
        chk("delta_hdr", 64'(out_data), 64'({8'hA5, seq0, 4'd6, 11'd0, 1'b1}));
        step(1'b0, 1'b1, 1'b0);
        chk("delta_lo", 64'(out_data), 64'h20);
        step(1'b0, 1'b1, 1'b0);
        chk("delta_hi", 64'(out_data), 64'h0);
        drain();

        // Drops: three mid-frame plus one on the last-word handshake
        drop0 = drop_cnt;
        seq0 = seq;
        cnt_v[0] = 64'h0000_0042_0000_1000;
        step(1'b1, 1'b1, 1'b0);
        cnt_v[0] = 64'h0000_0099_0000_0000;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
        n = 0;
        while (m_q.size() > 1 && n < 40) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("drop_last_visible", 64'(out_last), 64'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("drop_count", 64'(drop_cnt), 64'(drop0 + 4));
        chk("drop_busy", 64'(busy), 64'd0);
        step(1'b0, 1'b1, 1'b0);
        cnt_v[0] = 64'h0000_0042_0000_1100;
        step(1'b1, 1'b1, 1'b1);
        chk("drop_seq", 64'(out_data[23:16]), 64'(seq0 + 8'd1));
        step(1'b0, 1'b1, 1'b0);
        chk("drop_delta_base", 64'(out_data), 64'h100);
        drain();

        // Randomized traffic
        cnt_v[2] = 64'hFFFF_FFFF_FFFF_FF00;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) cnt_v[i] = cnt_v[i] + 64'($urandom_range(0, 3));
            step(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)));
        end
        drain();

        // Reset mid-frame
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_seq", 64'(seq), 64'd0);
        chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        cnt_v[0] = 64'h0000_0003_0000_0077;
        step(1'b1, 1'b1, 1'b1);
        chk("post_rst_hdr", 64'(out_data), 64'hA500_6001);
        step(1'b0, 1'b1, 1'b0);
        chk("post_rst_abs_lo", 64'(out_data), 64'h77);
        step(1'b0, 1'b1, 1'b0);
        chk("post_rst_abs_hi", 64'(out_data), 64'h3);
        drain();

        // Periodic trigger instance
        hdr_n = 0;
        ecount = 0;
        pv = 1'b0;
        @(negedge clk);
        rst_n_p = 1'b1;
        for (int e = 0; e < 160; e++) begin
            @(posedge clk);
            ecount++;
            @(negedge clk);
            if (out_valid_p && !pv) begin
                if (hdr_n < 3) begin
                    chk("per_edge", 64'(ecount), 64'(50 * (hdr_n + 1)));
                    chk("per_hdr", 64'(out_data_p), 64'({8'hA5, 8'(hdr_n), 4'd6, 11'd0, 1'b0}));
                end
                hdr_n++;
            end
            pv = out_valid_p;
        end
        chk("per_headers", 64'(hdr_n), 64'd3);
        chk("per_drop", 64'(drop_cnt_p), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
